// File: rtl/square_pipe_pkg.sv
// Shared types and arithmetic helpers for the square_pipe fixed-point datapath.
// Helpers operate on a wide signed container so any lane width up to 64 bits fits.
package square_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'b00,
    MODE_ABS    = 2'b01,
    MODE_PASS   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam int unsigned WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    wide_t value;
    logic  sat;
  } sat_t;

  // Drop the fractional bits of a product of two fixed-point values.
  function automatic wide_t dequantize(input wide_t v, input int unsigned frac_bits);
    return v >>> frac_bits;
  endfunction

  // Clamp to the signed range of a width-bit value and report whether clamping happened.
  function automatic sat_t saturate(input wide_t v, input int unsigned width);
    wide_t hi;
    wide_t lo;
    sat_t  r;
    hi      = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo      = -(wide_t'(1) <<< (width - 1));
    r.value = v;
    r.sat   = 1'b0;
    if (v > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/square_pipe_if.sv
// FIFO-facing handshake and data bundle of square_pipe.
// master is the pipeline side (drives the pop/push strobes), slave the FIFO side.
interface square_pipe_if #(
  parameter int DATA_SIZE = 32,
  parameter int CHANNELS  = 1
);
  logic                          in_rd_en;
  logic                          in_empty;
  logic [CHANNELS*DATA_SIZE-1:0] data_in;
  logic [1:0]                    mode_in;
  logic                          out_wr_en;
  logic                          out_full;
  logic [CHANNELS*DATA_SIZE-1:0] dout;
  logic [15:0]                   sat_count;

  modport master (
    output in_rd_en, out_wr_en, dout, sat_count,
    input  in_empty, data_in, mode_in, out_full
  );

  modport slave (
    input  in_rd_en, out_wr_en, dout, sat_count,
    output in_empty, data_in, mode_in, out_full
  );
endinterface

// File: rtl/square_pipe_lane.sv
// One lane of square_pipe: S1 widens/squares/abs, S2 dequantizes and saturates.
// Both stages advance together on adv; the valid bits live in the top level.
module square_lane
  import square_pipe_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int FRAC_BITS = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        adv,
  input  logic signed [DATA_SIZE-1:0] x,
  input  mode_e                       mode,
  output logic        [DATA_SIZE-1:0] y,
  output logic                        sat
);

  localparam int PW = 2 * DATA_SIZE;

  logic signed [PW-1:0] x_wide;
  logic signed [PW-1:0] s1_next;
  logic signed [PW-1:0] s1_data;
  mode_e                s1_mode;
  wide_t                s2_wide;
  sat_t                 s2_sat;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    x_wide  = PW'(x);
    s1_next = x_wide;
    case (mode)
      MODE_SQUARE: s1_next = x_wide * x_wide;
      MODE_ABS:    s1_next = x[DATA_SIZE-1] ? -x_wide : x_wide;
      default:     s1_next = x_wide;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so both stages shift on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_data <= '0;
      s1_mode <= MODE_PASS;
    end else if (adv) begin
      s1_data <= s1_next;
      s1_mode <= mode;
    end
  end

  always_comb begin
    s2_wide = wide_t'(s1_data);
    if (s1_mode == MODE_SQUARE) begin
      s2_wide = dequantize(s2_wide, FRAC_BITS);
    end
    s2_sat = saturate(s2_wide, DATA_SIZE);
  end

  // NOTE: the datapath registers are reset too, because y is the visible dout and must read 0 after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (adv) begin
      y   <= s2_sat.value[DATA_SIZE-1:0];
      sat <= s2_sat.sat;
    end
  end

endmodule

// File: rtl/square_pipe.sv
// Two-stage multi-lane square/abs/pass pipeline between two FWFT FIFOs.
// Owns the valid bits, the pop/push handshake and the saturation event counter.
module square_pipe
  import square_pipe_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int FRAC_BITS = 10,
  parameter int CHANNELS  = 1
) (
  input  logic         clock,
  input  logic         reset,
  square_pipe_if.master bus
);

  logic                adv;
  logic                s1_valid;
  logic                s2_valid;
  mode_e               in_mode;
  logic [CHANNELS-1:0] sat_flags;
  logic [16:0]         sat_sum;

  assign adv     = !s2_valid || !bus.out_full;
  assign in_mode = mode_e'(bus.mode_in);

  // Gated by reset so nothing is popped (and lost) while the pipeline is held in reset.
  assign bus.in_rd_en  = reset && !bus.in_empty && adv;
  assign bus.out_wr_en = s2_valid && !bus.out_full;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    square_lane #(
      .DATA_SIZE(DATA_SIZE),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .clock(clock),
      .reset(reset),
      .adv  (adv),
      .x    (bus.data_in[i*DATA_SIZE +: DATA_SIZE]),
      .mode (in_mode),
      .y    (bus.dout[i*DATA_SIZE +: DATA_SIZE]),
      .sat  (sat_flags[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_rd_en;
      s2_valid <= s1_valid;
    end
  end

  always_comb begin
    sat_sum = {1'b0, bus.sat_count};
    for (int i = 0; i < CHANNELS; i++) begin
      sat_sum = sat_sum + 17'(sat_flags[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.sat_count <= '0;
    end else if (bus.out_wr_en) begin
      bus.sat_count <= (sat_sum > 17'h0FFFF) ? 16'hFFFF : sat_sum[15:0];
    end
  end

endmodule

// File: tb/tb_square_pipe.sv
// Self-checking bench for square_pipe (4 lanes): directed cases, random backpressure,
// reset flush and sat_count stickiness, all against an arithmetic reference model.
module tb_square_pipe;

  localparam int DS = 32;
  localparam int FB = 10;
  localparam int CH = 4;
  localparam int W  = CH * DS;

  typedef struct {
    logic [W-1:0] data;
    int           nsat;
    int           cyc;
  } exp_t;

  logic clock;
  logic reset;

  square_pipe_if #(.DATA_SIZE(DS), .CHANNELS(CH)) bus ();

  square_pipe #(
    .DATA_SIZE(DS),
    .FRAC_BITS(FB),
    .CHANNELS (CH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   n_pops  = 0;
  int   n_wr    = 0;
  int   exp_sat = 0;
  bit   chk_lat = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: per-lane arithmetic on 64-bit integers, then clamp to the lane range.
  function automatic void model(input logic [W-1:0] din, input logic [1:0] mode,
                                output logic [W-1:0] res, output int nsat);
    longint x;
    longint v;
    longint maxv;
    longint minv;
    maxv = (longint'(1) << (DS - 1)) - 1;
    minv = -(longint'(1) << (DS - 1));
    nsat = 0;
    res  = '0;
    for (int i = 0; i < CH; i++) begin
      x = longint'(signed'(din[i*DS +: DS]));
      case (mode)
        2'b00:   v = (x * x) / (longint'(1) << FB);
        2'b01:   v = (x < 0) ? -x : x;
        default: v = x;
      endcase
      if (v > maxv) begin
        v = maxv;
        nsat++;
      end else if (v < minv) begin
        v = minv;
        nsat++;
      end
      res[i*DS +: DS] = v[DS-1:0];
    end
  endfunction

  function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < CH; i++) begin
      if ($urandom_range(0, 3) == 0) w[i*DS +: DS] = $urandom;
      else w[i*DS +: DS] = 32'($urandom_range(0, 8191)) - 32'd4096;
    end
    return w;
  endfunction

  // One clock cycle: drive inputs after the falling edge, then observe and score.
  task automatic step(input logic empty, input logic [W-1:0] din, input logic [1:0] mode,
                      input logic full);
    exp_t e;
    int   ns;
    @(negedge clock);
    bus.in_empty = empty;
    bus.data_in  = din;
    bus.mode_in  = mode;
    bus.out_full = full;
    #1;
    check("sat_count", 128'(bus.sat_count), 128'(exp_sat));
    if (full) check("wr_while_full", 128'(bus.out_wr_en), 128'(0));
    if (full && exp_q.size() == 2) begin
      check("pop_while_stalled", 128'(bus.in_rd_en), 128'(0));
      check("dout_hold", bus.dout, exp_q[0].data);
    end
    if (bus.out_wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("spurious_write", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("dout", bus.dout, e.data);
        if (chk_lat) check("latency", 128'(cyc - e.cyc), 128'(2));
        exp_sat = (exp_sat + e.nsat > 65535) ? 65535 : exp_sat + e.nsat;
      end
    end
    if (bus.in_rd_en) begin
      n_pops++;
      model(din, mode, e.data, ns);
      e.nsat = ns;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    check("occupancy_le_2", 128'(exp_q.size() <= 2), 128'(1));
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b1, '0, 2'b10, 1'b0);
    check("drained", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int start_pops;
    int bp_cycles;

    reset        = 1'b0;
    bus.in_empty = 1'b0;
    bus.data_in  = pack4(2048, 1, 2, 3);
    bus.mode_in  = 2'b00;
    bus.out_full = 1'b0;
    #1;
    check("rst_in_rd_en", 128'(bus.in_rd_en), 128'(0));
    check("rst_out_wr_en", 128'(bus.out_wr_en), 128'(0));
    check("rst_dout", bus.dout, 128'(0));
    check("rst_sat_count", 128'(bus.sat_count), 128'(0));
    repeat (2) @(negedge clock);
    bus.in_empty = 1'b1;
    reset        = 1'b1;

    // Directed values with latency checking; out_full stays low.
    chk_lat = 1'b1;
    step(1'b0, pack4(2048, 0, 0, 0), 2'b00, 1'b0);
    step(1'b0, pack4(-3072, 0, 0, 0), 2'b00, 1'b0);
    step(1'b0, pack4(1 << 21, 0, 0, 0), 2'b00, 1'b0);
    step(1'b0, pack4(int'(32'h8000_0000), 0, 0, 0), 2'b01, 1'b0);
    for (int m = 0; m < 4; m++) begin
      step(1'b0, pack4(-5, 7, 1024, -2048), 2'((m + 2) % 4), 1'b0);
    end
    drain();

    // Random data and modes under random output backpressure.
    chk_lat    = 1'b0;
    start_pops = n_pops;
    bp_cycles  = 0;
    while (n_pops - start_pops < 100 && bp_cycles < 2000) begin
      step(1'b0, rand_word(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      bp_cycles++;
    end
    check("bp_pops", 128'(n_pops - start_pops), 128'(100));
    drain();
    check("writes_eq_pops", 128'(n_wr), 128'(n_pops));

    // Two words in flight (held by out_full), then a one-cycle reset pulse.
    step(1'b0, pack4(111, 222, 333, 444), 2'b10, 1'b1);
    step(1'b0, pack4(-1, -2, -3, -4), 2'b01, 1'b1);
    @(negedge clock);
    bus.in_empty = 1'b0;
    reset        = 1'b0;
    #1;
    check("flush_in_rd_en", 128'(bus.in_rd_en), 128'(0));
    check("flush_out_wr_en", 128'(bus.out_wr_en), 128'(0));
    check("flush_dout", bus.dout, 128'(0));
    check("flush_sat_count", 128'(bus.sat_count), 128'(0));
    exp_q.delete();
    exp_sat      = 0;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) step(1'b1, '0, 2'b00, 1'b0);
    chk_lat = 1'b1;
    step(1'b0, pack4(2048, -3072, 1 << 21, 5), 2'b00, 1'b0);
    drain();

    // Saturation counter must stick at its maximum.
    for (int i = 0; i < 16385; i++) begin
      step(1'b0, pack4(1 << 21, 1 << 21, 1 << 21, 1 << 21), 2'b00, 1'b0);
    end
    drain();
    check("sat_sticky", 128'(bus.sat_count), 128'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/square_pipe.md
# square_pipe

Pipelined, multi-lane successor to the single-element square stage in the fixed-point datapath. It pops elements from an upstream first-word-fall-through FIFO and applies a per-element mode: square with dequantize, absolute value, or pass-through. Results are saturated to the data width and pushed to a downstream FIFO. It sustains one element per cycle, stalls cleanly on output backpressure, and counts saturation events for debug.

## Interface
- DATA_SIZE, 32, signed width of each lane element
- FRAC_BITS, 10, fractional bits of the fixed-point format; the dequantize shift amount
- CHANNELS, 1, number of parallel lanes packed into one FIFO word; all lanes share the handshake
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; asserting it (low) clears all state immediately
- in_rd_en  out  1  pop strobe to the input FIFO
- in_empty  in  1  input FIFO empty
- data_in  in  CHANNELS*DATA_SIZE  lane i occupies bits [i*DATA_SIZE +: DATA_SIZE], signed; valid whenever in_empty=0
- mode_in  in  2  per-element mode, sampled with data_in: 00 SQUARE, 01 ABS, 10 PASS, 11 reserved (behaves as PASS)
- out_wr_en  out  1  push strobe to the output FIFO
- out_full  in  1  output FIFO full
- dout  out  CHANNELS*DATA_SIZE  result word, same packing as data_in
- sat_count  out  16  saturated lane results since reset; sticks at 16'hFFFF

## Operation
- Two pipeline stages, S1 and S2, each holding a valid bit, CHANNELS lane values and flags.
- Advance enable: adv = !S2.valid || !out_full.
- in_rd_en = !in_empty && adv. It is combinational, with no dependency on in_rd_en itself.
- On adv, S2 loads S1 and S1 loads the new element. S1.valid is set to in_rd_en. When adv=0, all stages hold.
- S1 (per lane, x = lane input):
  - SQUARE: x*x at full 2*DATA_SIZE signed precision.
  - ABS: |x|, sign-extended to 2*DATA_SIZE.
  - PASS: x, sign-extended to 2*DATA_SIZE.
- S2 (per lane):
  - SQUARE: arithmetic right shift by FRAC_BITS. The product is non-negative, so this is truncation.
  - All modes: saturate to [-(2^(DATA_SIZE-1)), 2^(DATA_SIZE-1)-1] and record a per-lane sat flag.
- Output: out_wr_en = S2.valid && !out_full; dout = S2 data.
- dout is registered and holds its value while stalled.
- sat_count adds the number of set sat flags when the S2 word is written (out_wr_en=1), saturating at 16'hFFFF.

## Timing
- Reset values: in_rd_en=0, out_wr_en=0, dout=0, sat_count=0, both valid bits=0.
- Latency: an element popped in cycle t (in_rd_en=1) is written in cycle t+2 when out_full stays 0.
- Throughput: one word per cycle when in_empty=0 and out_full=0 continuously.
- out_full asserted with S2 valid:
  - out_wr_en=0 and in_rd_en=0.
  - Pipeline freezes and no data is lost or duplicated.
  - Resumes the cycle out_full deasserts.
- out_full asserted with S2 empty: the pipeline keeps filling until S2 is valid, so at most 2 words are held internally.
- in_empty=1: bubbles propagate (valid=0); out_wr_en never asserts for a bubble.
- Simultaneous pop and push in one cycle is the normal steady state.
- Reset asserted mid-operation: in-flight elements are discarded, outputs return to reset values asynchronously, and no write occurs until a new pop after reset release.
- mode_in travels with its element: a mode change between consecutive pops affects only the later element.

## Structure
- Shared globals package:
  - mode enum type (SQUARE, ABS, PASS, RSVD).
  - DEQUANTIZE function parameterised by FRAC_BITS.
  - Saturation function.
- Sub-module square_lane:
  - One lane's S1/S2 datapath plus its sat flag.
  - Instantiated CHANNELS times with a generate loop.
- Top level owns the valid bits, the handshake and sat_count.

## Test plan
Defaults DATA_SIZE=32, FRAC_BITS=10 unless noted.
- SQUARE, x=2048 (2.0) -> dout=4096, written exactly 2 cycles after the pop. x=-3072 -> 9216.
- Saturation: SQUARE x=2^21 -> 0x7FFFFFFF and sat_count=1. ABS x=-2^31 -> 0x7FFFFFFF and sat_count=2.
- Mixed modes back-to-back with CHANNELS=4, lanes {-5, 7, 1024, -2048}:
  - PASS -> identical.
  - ABS -> {5, 7, 1024, 2048}.
  - SQUARE -> {0, 0, 1024, 4096}.
  - mode 11 -> same as PASS.
- Backpressure: 100 random words, out_full toggled randomly and in_empty held low -> output sequence equals the model; no drop or duplicate; in_rd_en=0 whenever S2 is valid and out_full=1.
- Reset low for 1 cycle with 2 words in flight -> all outputs 0 immediately; no write of the flushed words; the next pop produces correct output.
- sat_count rollover: force 65540 saturating elements -> sat_count sticks at 16'hFFFF.
